// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: FWFT FIFO of retired-instruction records
// drained over valid/ready; drops and counts on overflow.
module retire_trace_buffer #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int ONLY_WB = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     retire_valid,
  input  logic [31:0]              retire_pc,
  input  logic [31:0]              retire_instr,
  input  logic                     retire_we,
  input  logic [4:0]               retire_rd,
  input  logic [31:0]              retire_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_stamp,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_we,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] stamp;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             rec_d;
  rec_t             head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic             wb_ok, cap, full, empty;
  logic             push, pop, drop;

  assign wb_ok = retire_we & (retire_rd != 5'd0);
  assign cap   = retire_valid & ((ONLY_WB != 0) ? wb_ok : 1'b1);
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = ~empty & out_ready;
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  always_comb begin
    rec_d       = '0;
    rec_d.stamp = cyc_q;
    rec_d.pc    = retire_pc;
    rec_d.instr = retire_instr;
    rec_d.we    = wb_ok;
    rec_d.rd    = retire_rd;
    rec_d.wdata = wb_ok ? retire_wdata : 32'd0;
  end

  always_comb begin
    cyc_d    = cyc_q + 32'd1;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // clear applies first so a same-cycle drop still registers
  always_comb begin
    cnt_base   = clr_stats ? '0 : drop_cnt_q;
    drop_cnt_d = cnt_base;
    if (drop && cnt_base != '1)
      drop_cnt_d = cnt_base + CNT_W'(1);
    overflow_d = (overflow_q & ~clr_stats) | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= rec_d;
  end

  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid = ~empty;
  assign out_stamp = head.stamp;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_we    = head.we;
  assign out_rd    = head.rd;
  assign out_wdata = head.wdata;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
